// File: rtl/fib_stack_ctrl_if.sv
// Request/response bundle between the Fibonacci main controller and its frame stack.
interface fib_stack_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) ();
    logic          pushSig;
    logic          popSig;
    logic          flush;
    logic [DW-1:0] push_n;
    logic [DW-1:0] push_flag;
    logic [DW-1:0] push_ret;
    logic [DW-1:0] pop_n;
    logic [DW-1:0] pop_flag;
    logic [DW-1:0] pop_ret;
    logic          readySig;
    logic          full;
    logic          empty;
    logic [AW:0]   depth;
    logic          ovf;
    logic          udf;
    logic          perr;

    modport master (
        output pushSig, popSig, flush, push_n, push_flag, push_ret,
        input  pop_n, pop_flag, pop_ret, readySig, full, empty, depth, ovf, udf, perr
    );

    modport slave (
        input  pushSig, popSig, flush, push_n, push_flag, push_ret,
        output pop_n, pop_flag, pop_ret, readySig, full, empty, depth, ovf, udf, perr
    );
endinterface

// File: rtl/fib_stack_ctrl.sv
// Frame-stack controller: LIFO of {n, flag, ret} call frames with sticky error tracking.
module fib_stack_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    fib_stack_ctrl_if.slave  bus
);
    localparam int unsigned SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] n;
        logic [DW-1:0] flag;
        logic [DW-1:0] ret;
    } frame_t;

    typedef enum logic [1:0] {IDLE, PUSH, POP, ACK} state_t;

    state_t         state, next_state;
    logic [SPW-1:0] sp;
    frame_t         hold_q;
    frame_t         pop_q;
    frame_t         mem [DEPTH];
    logic           ready_q, ovf_q, udf_q, perr_q;

    logic           full_c, empty_c;
    logic [AW-1:0]  wr_idx_c, rd_idx_c;
    logic           capture_c, flush_c, perr_set_c, push_wr_c, pop_rd_c, ovf_set_c, udf_set_c;

    // Stack status straight from the pointer.
    assign full_c   = (sp == SP_FULL);
    assign empty_c  = (sp == '0);
    assign wr_idx_c = AW'(sp);
    assign rd_idx_c = AW'(sp - SPW'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state and per-cycle datapath strobes.
    always_comb begin
        next_state = state;
        capture_c  = 1'b0;
        flush_c    = 1'b0;
        perr_set_c = 1'b0;
        push_wr_c  = 1'b0;
        pop_rd_c   = 1'b0;
        ovf_set_c  = 1'b0;
        udf_set_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush) begin
                    flush_c    = 1'b1;
                    next_state = ACK;
                end else if (bus.pushSig && bus.popSig) begin
                    perr_set_c = 1'b1;
                    next_state = ACK;
                end else if (bus.pushSig) begin
                    capture_c  = 1'b1;
                    next_state = PUSH;
                end else if (bus.popSig) begin
                    next_state = POP;
                end
            end
            PUSH: begin
                if (!full_c) push_wr_c = 1'b1;
                else         ovf_set_c = 1'b1;
                next_state = ACK;
            end
            POP: begin
                if (!empty_c) pop_rd_c  = 1'b1;
                else          udf_set_c = 1'b1;
                next_state = ACK;
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pointer, holding register, popped frame, completion pulse and sticky errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp      <= '0;
            hold_q  <= '0;
            pop_q   <= '0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            ready_q <= (next_state == ACK);
            if (capture_c) hold_q <= '{n: bus.push_n, flag: bus.push_flag, ret: bus.push_ret};
            if (pop_rd_c)  pop_q  <= mem[rd_idx_c];
            if (flush_c)        sp <= '0;
            else if (push_wr_c) sp <= sp + SPW'(1);
            else if (pop_rd_c)  sp <= sp - SPW'(1);
            if (flush_c) begin
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
                perr_q <= 1'b0;
            end else begin
                if (ovf_set_c)  ovf_q  <= 1'b1;
                if (udf_set_c)  udf_q  <= 1'b1;
                if (perr_set_c) perr_q <= 1'b1;
            end
        end
    end

    // Frame storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_wr_c) mem[wr_idx_c] <= hold_q;
    end

    assign bus.pop_n    = pop_q.n;
    assign bus.pop_flag = pop_q.flag;
    assign bus.pop_ret  = pop_q.ret;
    assign bus.readySig = ready_q;
    assign bus.full     = full_c;
    assign bus.empty    = empty_c;
    assign bus.depth    = sp;
    assign bus.ovf      = ovf_q;
    assign bus.udf      = udf_q;
    assign bus.perr     = perr_q;
endmodule

// File: tb/tb_fib_stack_ctrl.sv
// Directed bench for fib_stack_ctrl.
module tb_fib_stack_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    fib_stack_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    fib_stack_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, return cycles until readySig, then confirm the pulse is one cycle wide.
    task automatic do_op(input logic p, input logic q, input logic f,
                         input logic [7:0] n, input logic [7:0] fl, input logic [7:0] r,
                         output int lat);
        bus.pushSig = p; bus.popSig = q; bus.flush = f;
        bus.push_n = n;  bus.push_flag = fl; bus.push_ret = r;
        tick();
        bus.pushSig = 1'b0; bus.popSig = 1'b0; bus.flush = 1'b0;
        bus.push_n = 8'hee; bus.push_flag = 8'hee; bus.push_ret = 8'hee;
        lat = 1;
        while (!bus.readySig && lat < 10) begin
            tick();
            lat++;
        end
        tick();
        chk("ready_one_cycle", 32'(bus.readySig), 32'd0);
    endtask

    function automatic logic [31:0] popw();
        return {8'h00, bus.pop_n, bus.pop_flag, bus.pop_ret};
    endfunction

    initial begin
        int   lat;
        logic seen;
        logic [4:0] pat;

        bus.pushSig = 1'b0; bus.popSig = 1'b0; bus.flush = 1'b0;
        bus.push_n = '0; bus.push_flag = '0; bus.push_ret = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_depth", 32'(bus.depth), 32'd0);
        chk("rst_ready", 32'(bus.readySig), 32'd0);
        chk("rst_pop", popw(), 32'h0);
        chk("rst_errs", {29'd0, bus.ovf, bus.udf, bus.perr}, 32'd0);
        rst = 1'b1;
        tick();

        // Reset mid-PUSH aborts without readySig.
        bus.pushSig = 1'b1; bus.push_n = 8'h77;
        tick();
        bus.pushSig = 1'b0;
        rst = 1'b0;
        #1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (bus.readySig) seen = 1'b1;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        chk("abort_empty", 32'(bus.empty), 32'd1);
        chk("abort_depth", 32'(bus.depth), 32'd0);
        chk("abort_errs", {29'd0, bus.ovf, bus.udf, bus.perr}, 32'd0);
        rst = 1'b1;
        tick();

        // Two pushes, two pops.
        do_op(1, 0, 0, 8'd5, 8'd1, 8'd0, lat);
        chk("push1_lat", 32'(lat), 32'd2);
        do_op(1, 0, 0, 8'd4, 8'd2, 8'd3, lat);
        chk("push2_lat", 32'(lat), 32'd2);
        chk("push2_depth", 32'(bus.depth), 32'd2);
        do_op(0, 1, 0, 8'd0, 8'd0, 8'd0, lat);
        chk("pop1_lat", 32'(lat), 32'd2);
        chk("pop1_frame", popw(), 32'h00040203);
        do_op(0, 1, 0, 8'd0, 8'd0, 8'd0, lat);
        chk("pop2_lat", 32'(lat), 32'd2);
        chk("pop2_frame", popw(), 32'h00050100);
        chk("pop2_empty", 32'(bus.empty), 32'd1);

        // Fill to DEPTH, overflow, drain in LIFO order.
        for (int i = 0; i < 16; i++) begin
            do_op(1, 0, 0, 8'(i), 8'(8'h10 + i), 8'(8'h20 + i), lat);
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_depth", 32'(bus.depth), 32'd16);
        chk("fill_ovf_clear", 32'(bus.ovf), 32'd0);
        do_op(1, 0, 0, 8'd99, 8'd99, 8'd99, lat);
        chk("ovf_lat", 32'(lat), 32'd2);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        chk("ovf_depth", 32'(bus.depth), 32'd16);
        chk("ovf_full", 32'(bus.full), 32'd1);
        for (int i = 15; i >= 0; i--) begin
            do_op(0, 1, 0, 8'd0, 8'd0, 8'd0, lat);
            chk($sformatf("drain_%0d", i), popw(),
                {8'h00, 8'(i), 8'(8'h10 + i), 8'(8'h20 + i)});
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Pop on empty.
        do_op(0, 1, 0, 8'd0, 8'd0, 8'd0, lat);
        chk("udf_lat", 32'(lat), 32'd2);
        chk("udf_set", 32'(bus.udf), 32'd1);
        chk("udf_pop_held", popw(), 32'h00001020);
        chk("udf_depth", 32'(bus.depth), 32'd0);
        chk("udf_ovf_sticky", 32'(bus.ovf), 32'd1);

        // Simultaneous push+pop, then flush.
        for (int i = 0; i < 3; i++) do_op(1, 0, 0, 8'(i), 8'd0, 8'd0, lat);
        chk("perr_pre_depth", 32'(bus.depth), 32'd3);
        do_op(1, 1, 0, 8'd50, 8'd50, 8'd50, lat);
        chk("perr_lat", 32'(lat), 32'd1);
        chk("perr_set", 32'(bus.perr), 32'd1);
        chk("perr_depth", 32'(bus.depth), 32'd3);
        do_op(0, 0, 1, 8'd0, 8'd0, 8'd0, lat);
        chk("flush_lat", 32'(lat), 32'd1);
        chk("flush_depth", 32'(bus.depth), 32'd0);
        chk("flush_errs", {29'd0, bus.ovf, bus.udf, bus.perr}, 32'd0);

        // pushSig held for five edges: one push per IDLE visit.
        bus.pushSig = 1'b1; bus.push_n = 8'd42;
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pat[i] = bus.readySig;
        end
        bus.pushSig = 1'b0;
        chk("hold_ready_pattern", 32'(pat), 32'b10010);
        tick();
        chk("hold_ready_low", 32'(bus.readySig), 32'd0);
        chk("hold_depth", 32'(bus.depth), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
